// File: rtl/note_sequencer.sv
// Step-table melody sequencer: ticks at the sample rate, advances one oscillator per tick
// and registers its sample for the DAC/mixer. Optional rests: define NOTE_SEQUENCER_REST_EN.
module note_sequencer #(
  parameter int width_p     = 12,
  parameter int num_notes_p = 4,
  parameter int steps_p     = 8,
  parameter int dur_width_p = 16,
  parameter int clk_div_p   = 2268
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             start_i,
  input  logic                             stop_i,
  input  logic                             loop_i,
  input  logic [$clog2(steps_p+1)-1:0]     seq_len_i,
  input  logic                             wr_en_i,
  input  logic [$clog2(steps_p)-1:0]       wr_addr_i,
  input  logic [$clog2(num_notes_p):0]     wr_note_i,
  input  logic [dur_width_p-1:0]           wr_dur_i,
  input  logic [num_notes_p*width_p-1:0]   osc_data_i,
  output logic [num_notes_p-1:0]           osc_ready_o,
  output logic signed [width_p-1:0]        data_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overrun_o
);

  localparam int NIW = $clog2(num_notes_p);
  localparam int NW  = NIW + 1;
  localparam int SW  = $clog2(steps_p);
  localparam int LW  = $clog2(steps_p + 1);
  localparam int TW  = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(clk_div_p - 1);
  localparam logic [LW-1:0] STEPS_L  = LW'(steps_p);

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t                 state_q;
  logic [SW-1:0]          step_q;
  logic [LW-1:0]          len_q;
  logic [dur_width_p-1:0] dur_cnt_q;
  logic [TW-1:0]          tick_cnt_q;

  logic [NW-1:0]          note_mem [steps_p];
  logic [dur_width_p-1:0] dur_mem  [steps_p];

  logic [NW-1:0]          cur_note;
  logic [NIW-1:0]         note_idx;
  logic [dur_width_p-1:0] cur_dur;
  logic                   rest;
  logic                   tick;
  logic                   accept;
  logic                   fire;
  logic                   dur_last;
  logic                   step_last;
  logic [width_p-1:0]     osc_sample;
  logic [width_p-1:0]     sample;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      note_mem[wr_addr_i] <= wr_note_i;
      dur_mem[wr_addr_i]  <= wr_dur_i;
    end
  end

  assign cur_note = note_mem[step_q];
  assign cur_dur  = dur_mem[step_q];
  assign note_idx = cur_note[NIW-1:0];

`ifdef NOTE_SEQUENCER_REST_EN
  assign rest = cur_note[NW-1];
`else
  logic unused_rest_flag;
  assign unused_rest_flag = cur_note[NW-1];
  assign rest = 1'b0;
`endif

  // Output handshake: a sample transfers when valid_o && ready_i. A tick may load a new
  // sample only when the output slot is empty or being drained that same cycle; data_o
  // never changes while valid_o && !ready_i.
  assign tick      = (state_q == PLAY) && (tick_cnt_q == TICK_MAX) && !stop_i;
  assign accept    = !valid_o || ready_i;
  assign fire      = tick && accept;
  assign dur_last  = (cur_dur == '0) || (dur_cnt_q == cur_dur - dur_width_p'(1));
  assign step_last = (LW'(step_q) == len_q - LW'(1));
  assign busy_o    = (state_q == PLAY);

  always_comb begin
    osc_sample = '0;
    for (int k = 0; k < num_notes_p; k++) begin
      if (note_idx == NIW'(k)) osc_sample = osc_data_i[k*width_p +: width_p];
    end
  end

  assign sample = rest ? '0 : osc_sample;

  always_comb begin
    osc_ready_o = '0;
    if (fire && !rest) osc_ready_o[note_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      step_q     <= '0;
      len_q      <= '0;
      dur_cnt_q  <= '0;
      tick_cnt_q <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      done_o     <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;

      if (fire) begin
        data_o  <= sample;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      if (tick && !accept) overrun_o <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            overrun_o <= 1'b0;
            if (seq_len_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state_q    <= PLAY;
              step_q     <= '0;
              dur_cnt_q  <= '0;
              tick_cnt_q <= '0;
              valid_o    <= 1'b0;
              // Lengths beyond the table depth play the whole table.
              len_q      <= (seq_len_i > STEPS_L) ? STEPS_L : seq_len_i;
            end
          end
        end
        PLAY: begin
          if (stop_i) begin
            state_q    <= IDLE;
            valid_o    <= 1'b0;
            tick_cnt_q <= '0;
          end else if (tick) begin
            tick_cnt_q <= '0;
            if (dur_last) begin
              dur_cnt_q <= '0;
              if (step_last) begin
                if (loop_i) begin
                  step_q <= '0;
                end else begin
                  state_q <= IDLE;
                  done_o  <= 1'b1;
                end
              end else begin
                step_q <= step_q + SW'(1);
              end
            end else begin
              dur_cnt_q <= dur_cnt_q + dur_width_p'(1);
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Plays a programmed melody on a bank of fixed-frequency wavetable oscillators (one per note).
- Holds a small step table; each step is a note index plus a duration in samples.
- Generates the sample-rate tick and pulses the `ready_i` of the active oscillator once per sample.
- Captures the selected oscillator's sample into a registered valid/ready output for the DAC/mixer path.

Parameters:
- width_p, 12: sample width, signed.
- num_notes_p, 4: number of oscillators. Power of two, ≥2.
- steps_p, 8: step-table depth.
- dur_width_p, 16: duration field width, in samples.
- clk_div_p, 2268: clocks per sample tick (100 MHz / 44.1 kHz).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  begin playback from step 0.
- stop_i  in  1  abort playback.
- loop_i  in  1  repeat the sequence after the last step (sampled every step wrap).
- seq_len_i  in  $clog2(steps_p+1)  number of steps to play; sampled at start.
- wr_en_i  in  1  step-table write strobe.
- wr_addr_i  in  $clog2(steps_p)  step-table write address.
- wr_note_i  in  $clog2(num_notes_p)+1  note field; MSB is the rest flag (see Optional Feature).
- wr_dur_i  in  dur_width_p  step duration, in samples.
- osc_data_i  in  num_notes_p*width_p  oscillator outputs; oscillator k occupies slice [k*width_p +: width_p].
- osc_ready_o  out  num_notes_p  one-hot, single-cycle advance pulse to an oscillator.
- data_o  out  width_p  signed output sample.
- valid_o  out  1  output sample valid.
- ready_i  in  1  downstream accepts the sample.
- busy_o  out  1  high in PLAY.
- done_o  out  1  one-cycle pulse when the sequence ends.
- overrun_o  out  1  sticky; a sample was dropped. Cleared only by reset or start.

Behaviour:
- Reset values: every output 0. State IDLE; step, duration and tick counters 0. The step table is not reset (contents undefined until written).
- FSM states: IDLE, PLAY.
  - IDLE→PLAY on start_i when seq_len_i≠0. This also clears step, duration count, tick count, valid_o and overrun_o.
  - start_i with seq_len_i==0: stay in IDLE and pulse done_o on the next cycle.
  - start_i while in PLAY is ignored.
  - stop_i in PLAY → IDLE next cycle and clears valid_o.
  - stop_i has priority over start_i in the same cycle.
- Tick counter: runs only in PLAY, counting 0..clk_div_p-1. The tick fires in the cycle where the count equals clk_div_p-1, then wraps to 0.
- On a tick, with n = note of the current step:
  - If !valid_o or ready_i is high that cycle: data_o ← osc_data_i[n] slice, valid_o ← 1, and osc_ready_o[n] pulses high in the same cycle.
  - The oscillator registers its output, so the next sample appears one clock later.
  - Otherwise (valid_o && !ready_i): the sample is dropped, overrun_o is set, and no oscillator advances.
- Handshake:
  - Transfer occurs when valid_o && ready_i.
  - If no new tick coincides with the transfer, valid_o falls the next cycle.
  - data_o is stable while valid_o && !ready_i.
- Duration:
  - The duration count increments on every tick, whether or not the sample was dropped.
  - When the count equals max(dur,1)-1 on a tick, it resets to 0 and the step advances. A duration of 0 behaves as 1.
- Last step (step == len-1) advancing:
  - loop_i high: step wraps to 0.
  - loop_i low: go to IDLE and pulse done_o one cycle later. A pending valid_o is kept until it is consumed.
- Step-table access:
  - Reads are asynchronous at the step index, taken on the tick.
  - Writes are allowed in any state and take effect at the next tick that reads that address.
- Osc ready timing: osc_ready_o is never asserted outside a tick cycle. At most one bit is set at a time.
- Reset mid-playback: immediate return to IDLE. All outputs go low asynchronously.

Optional Feature:
- Macro: NOTE_SEQUENCER_REST_EN.
- Defined: a note field with MSB=1 is a rest. Ticks during a rest produce data_o=0 with valid_o=1 under the same handshake/overrun rules, and no osc_ready_o pulse. Duration counting is unchanged.
- Undefined: the MSB is ignored and the low bits select the oscillator.

Test Plan:
- Basic step: clk_div_p=4; table {note1, dur3}; len=1; loop=0; ready_i=1; start → osc_ready_o=4'b0010 on 3 ticks 4 clocks apart; data_o = osc slice 1 each tick; done_o one cycle after the 3rd tick; busy_o low.
- Multi-step loop: steps {0,d2},{2,d1},{3,d0}; len=3; loop=1 → osc_ready_o one-hot sequence 0,0,2,3,0,0,2,3…; stop_i mid-run → IDLE next cycle, valid_o=0.
- Backpressure: ready_i=0 over two ticks → first sample held and stable; second dropped; overrun_o=1; no osc_ready_o on the dropped tick; step still advances per duration. Start then clears overrun_o.
- Edge starts: seq_len_i=0 start → no PLAY, done_o pulse. start_i with stop_i in the same cycle → remains IDLE. start_i during PLAY → no restart.
- Async reset: assert reset_i mid-PLAY between clock edges → valid_o, busy_o and osc_ready_o go 0 without waiting for a clock edge; restart after release plays from step 0.
- NOTE_SEQUENCER_REST_EN: step note = 3'b100 → data_o=0, valid_o=1, osc_ready_o=0 for the step's duration. Without the macro, the same code drives oscillator 0.
